// File: rtl/rvfi_commit_gen.sv
// RVFI commit-stream generator: emits a deterministic run of ADDI/trap records and a tohost store.
// Optional macro RVFI_GEN_COMPRESSED_EN selects a two-cycle C.SD tohost store.

package rvfi_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [63:0] rs1_rdata;
        logic [63:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
        logic [63:0] mem_addr;
        logic [7:0]  mem_rmask;
        logic [7:0]  mem_wmask;
        logic [63:0] mem_rdata;
        logic [63:0] mem_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_commit_gen
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter logic [63:0] BOOT_ADDR       = 64'h8000_0000,
    parameter logic [63:0] TOHOST_ADDR     = 64'h8000_1000,
    parameter int unsigned NUM_INSNS       = 5,
    parameter int unsigned TRAP_PERIOD     = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                stall_i,
    input  logic [30:0]                         exit_code_i,
    output rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_o,
    output logic                                busy_o,
    output logic                                done_o
);

    typedef enum logic [1:0] {IDLE, RUN, TOHOST, DONE} state_e;

    localparam int unsigned TP_SAFE   = (TRAP_PERIOD == 0) ? 1 : TRAP_PERIOD;
    localparam logic [63:0] TOHOST_PC = BOOT_ADDR + 64'(NUM_INSNS) * 64'd4;

`ifdef RVFI_GEN_COMPRESSED_EN
    localparam logic [31:0] STORE_INSN = 32'h0000_e188;
`else
    localparam logic [31:0] STORE_INSN = 32'h00a5_b023;
`endif

    state_e                             state_q, state_d;
    logic [31:0]                        idx_q, idx_d;
    logic [30:0]                        exit_q, exit_d;
    rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_q, rvfi_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
`ifdef RVFI_GEN_COMPRESSED_EN
    logic                               phase_q, phase_d;
`endif

    function automatic rvfi_instr_t make_record(input logic [31:0] n);
        rvfi_instr_t r;
        logic [31:0] rd_full;
        logic [11:0] imm;
        r          = '0;
        r.mode     = 2'b11;
        r.pc_rdata = BOOT_ADDR + {30'b0, n, 2'b00};
        rd_full    = (n % 32'd31) + 32'd1;
        imm        = n[11:0];
        if ((TRAP_PERIOD != 0) && (((n + 32'd1) % TP_SAFE) == 32'd0)) begin
            r.trap = 1'b1;
        end else begin
            r.valid    = 1'b1;
            r.insn     = {imm, 5'b00000, 3'b000, rd_full[4:0], 7'b0010011};
            r.rd_addr  = rd_full[4:0];
            r.rd_wdata = {{52{imm[11]}}, imm};
        end
        return r;
    endfunction

    // Retiring half of the store carries valid/pc; the memory half carries the write.
    function automatic rvfi_instr_t tohost_record(input logic retire, input logic with_mem,
                                                  input logic [30:0] code);
        rvfi_instr_t r;
        r      = '0;
        r.mode = 2'b11;
        r.insn = STORE_INSN;
        if (retire) begin
            r.valid    = 1'b1;
            r.pc_rdata = TOHOST_PC;
        end else begin
            r.valid    = 1'b0;
        end
        if (with_mem) begin
            r.mem_addr  = TOHOST_ADDR;
            r.mem_wmask = 8'hff;
            r.mem_wdata = {32'b0, code, 1'b1};
        end else begin
            r.mem_wdata = 64'd0;
        end
        return r;
    endfunction

    // Next-state and next-record computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exit_d  = exit_q;
        rvfi_d  = '0;
        done_d  = done_q;
`ifdef RVFI_GEN_COMPRESSED_EN
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    exit_d  = exit_code_i;
                    idx_d   = 32'd0;
                    state_d = (NUM_INSNS == 0) ? TOHOST : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
                        if ((idx_q + 32'(k)) < NUM_INSNS) begin
                            rvfi_d[k] = make_record(idx_q + 32'(k));
                        end else begin
                            rvfi_d[k] = '0;
                        end
                    end
                    idx_d = idx_q + 32'(NR_COMMIT_PORTS);
                    if ((idx_q + 32'(NR_COMMIT_PORTS)) >= NUM_INSNS) begin
                        state_d = TOHOST;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            TOHOST: begin
                if (!stall_i) begin
`ifdef RVFI_GEN_COMPRESSED_EN
                    if (!phase_q) begin
                        rvfi_d[0] = tohost_record(1'b0, 1'b1, exit_q);
                        phase_d   = 1'b1;
                    end else begin
                        rvfi_d[0] = tohost_record(1'b1, 1'b0, exit_q);
                        phase_d   = 1'b0;
                        state_d   = DONE;
                        done_d    = 1'b1;
                    end
`else
                    rvfi_d[0] = tohost_record(1'b1, 1'b1, exit_q);
                    state_d   = DONE;
                    done_d    = 1'b1;
`endif
                end else begin
                    state_d = TOHOST;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == TOHOST);
    end

    // State and registered-output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 32'd0;
            exit_q  <= 31'd0;
            rvfi_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RVFI_GEN_COMPRESSED_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exit_q  <= exit_d;
            rvfi_q  <= rvfi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RVFI_GEN_COMPRESSED_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign rvfi_o = rvfi_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_rvfi_commit_gen.sv
// Directed table-driven bench for rvfi_commit_gen: default, trapping and zero-length configurations.
`timescale 1ns/1ps
module tb_rvfi_commit_gen;
    import rvfi_pkg::*;

    typedef struct {
        logic        start;
        logic        stall;
        logic [30:0] exit_code;
        rvfi_instr_t e0;
        rvfi_instr_t e1;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_m = 1'b0, start_t = 1'b0, start_z = 1'b0;
    logic stall = 1'b0;
    logic [30:0] exit_code = 31'd0;
    rvfi_instr_t [1:0] o_m, o_t, o_z;
    logic busy_m, busy_t, busy_z, done_m, done_t, done_z;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];
    rvfi_instr_t zr;

    always #5 clk = ~clk;

    rvfi_commit_gen #(.NR_COMMIT_PORTS(2), .NUM_INSNS(5), .TRAP_PERIOD(0)) u_main (
        .clk_i(clk), .rst_i(rst), .start_i(start_m), .stall_i(stall), .exit_code_i(exit_code),
        .rvfi_o(o_m), .busy_o(busy_m), .done_o(done_m));
    rvfi_commit_gen #(.NR_COMMIT_PORTS(2), .NUM_INSNS(6), .TRAP_PERIOD(3)) u_trap (
        .clk_i(clk), .rst_i(rst), .start_i(start_t), .stall_i(stall), .exit_code_i(exit_code),
        .rvfi_o(o_t), .busy_o(busy_t), .done_o(done_t));
    rvfi_commit_gen #(.NR_COMMIT_PORTS(2), .NUM_INSNS(0), .TRAP_PERIOD(0)) u_zero (
        .clk_i(clk), .rst_i(rst), .start_i(start_z), .stall_i(stall), .exit_code_i(exit_code),
        .rvfi_o(o_z), .busy_o(busy_z), .done_o(done_z));

    function automatic rvfi_instr_t addi(input logic [63:0] pc, input logic [31:0] insn,
                                         input logic [4:0] rd, input logic [63:0] wd);
        rvfi_instr_t r = '0;
        r.valid = 1'b1; r.mode = 2'b11; r.pc_rdata = pc; r.insn = insn;
        r.rd_addr = rd; r.rd_wdata = wd;
        return r;
    endfunction

    function automatic rvfi_instr_t trp(input logic [63:0] pc);
        rvfi_instr_t r = '0;
        r.trap = 1'b1; r.mode = 2'b11; r.pc_rdata = pc;
        return r;
    endfunction

    function automatic rvfi_instr_t st(input logic [63:0] pc, input logic [31:0] insn, input logic v,
                                       input logic [63:0] addr, input logic [7:0] mask,
                                       input logic [63:0] wd);
        rvfi_instr_t r = '0;
        r.valid = v; r.mode = 2'b11; r.pc_rdata = pc; r.insn = insn;
        r.mem_addr = addr; r.mem_wmask = mask; r.mem_wdata = wd;
        return r;
    endfunction

    function automatic vec_t vr(input logic s, input logic sl, input logic [30:0] ec,
                                input rvfi_instr_t e0, input rvfi_instr_t e1,
                                input logic b, input logic d);
        vec_t v;
        v.start = s; v.stall = sl; v.exit_code = ec; v.e0 = e0; v.e1 = e1; v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic chk_port(input string name, input rvfi_instr_t act, input rvfi_instr_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got v=%0b t=%0b m=%0d pc=%h insn=%h rd=%0d wd=%h ma=%h wm=%h mw=%h, want v=%0b t=%0b m=%0d pc=%h insn=%h rd=%0d wd=%h ma=%h wm=%h mw=%h",
                     name, act.valid, act.trap, act.mode, act.pc_rdata, act.insn, act.rd_addr,
                     act.rd_wdata, act.mem_addr, act.mem_wmask, act.mem_wdata,
                     exp.valid, exp.trap, exp.mode, exp.pc_rdata, exp.insn, exp.rd_addr,
                     exp.rd_wdata, exp.mem_addr, exp.mem_wmask, exp.mem_wdata);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic grab(input int which, output rvfi_instr_t a0, output rvfi_instr_t a1,
                        output logic b, output logic d);
        case (which)
            0: begin a0 = o_m[0]; a1 = o_m[1]; b = busy_m; d = done_m; end
            1: begin a0 = o_t[0]; a1 = o_t[1]; b = busy_t; d = done_t; end
            default: begin a0 = o_z[0]; a1 = o_z[1]; b = busy_z; d = done_z; end
        endcase
    endtask

    task automatic run_table(input int which, input string tag);
        rvfi_instr_t a0, a1;
        logic b, d;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start_m = (which == 0) ? tbl[i].start : 1'b0;
            start_t = (which == 1) ? tbl[i].start : 1'b0;
            start_z = (which == 2) ? tbl[i].start : 1'b0;
            stall = tbl[i].stall;
            exit_code = tbl[i].exit_code;
            @(posedge clk);
            #1;
            grab(which, a0, a1, b, d);
            chk_port($sformatf("%s row%0d port0", tag, i), a0, tbl[i].e0);
            chk_port($sformatf("%s row%0d port1", tag, i), a1, tbl[i].e1);
            chk_bit($sformatf("%s row%0d busy", tag, i), b, tbl[i].busy);
            chk_bit($sformatf("%s row%0d done", tag, i), d, tbl[i].done);
        end
        @(negedge clk);
        start_m = 1'b0; start_t = 1'b0; start_z = 1'b0; stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        zr = '0;
        // Reset state of every instance while rst is held.
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            rvfi_instr_t a0, a1;
            logic b, d;
            grab(w, a0, a1, b, d);
            chk_port($sformatf("reset inst%0d port0", w), a0, zr);
            chk_port($sformatf("reset inst%0d port1", w), a1, zr);
            chk_bit($sformatf("reset inst%0d busy", w), b, 1'b0);
            chk_bit($sformatf("reset inst%0d done", w), d, 1'b0);
        end
        @(negedge clk); rst = 1'b0;

        // Main run: exit code latched as 5, stall mid-run, start ignored in RUN/DONE.
        tbl.delete();
        tbl.push_back(vr(1, 0, 31'd5, zr, zr, 1, 0));
        tbl.push_back(vr(0, 0, 31'd9, addi(64'h8000_0000, 32'h0000_0093, 5'd1, 64'd0),
                         addi(64'h8000_0004, 32'h0010_0113, 5'd2, 64'd1), 1, 0));
        tbl.push_back(vr(0, 1, 31'd9, zr, zr, 1, 0));
        tbl.push_back(vr(0, 1, 31'd9, zr, zr, 1, 0));
        tbl.push_back(vr(0, 1, 31'd9, zr, zr, 1, 0));
        tbl.push_back(vr(1, 0, 31'd9, addi(64'h8000_0008, 32'h0020_0193, 5'd3, 64'd2),
                         addi(64'h8000_000c, 32'h0030_0213, 5'd4, 64'd3), 1, 0));
        tbl.push_back(vr(0, 0, 31'd9, addi(64'h8000_0010, 32'h0040_0293, 5'd5, 64'd4), zr, 1, 0));
`ifdef RVFI_GEN_COMPRESSED_EN
        tbl.push_back(vr(0, 0, 31'd9, st(64'd0, 32'h0000_e188, 0, 64'h8000_1000, 8'hff, 64'hb), zr, 1, 0));
        tbl.push_back(vr(1, 0, 31'd9, st(64'h8000_0014, 32'h0000_e188, 1, 64'd0, 8'h00, 64'd0), zr, 0, 1));
`else
        tbl.push_back(vr(0, 0, 31'd9, st(64'h8000_0014, 32'h00a5_b023, 1, 64'h8000_1000, 8'hff, 64'hb), zr, 0, 1));
        tbl.push_back(vr(1, 0, 31'd9, zr, zr, 0, 1));
`endif
        tbl.push_back(vr(1, 0, 31'd9, zr, zr, 0, 1));
        run_table(0, "main");

        // Trap period 3 over six indices.
        tbl.delete();
        tbl.push_back(vr(1, 0, 31'd0, zr, zr, 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, addi(64'h8000_0000, 32'h0000_0093, 5'd1, 64'd0),
                         addi(64'h8000_0004, 32'h0010_0113, 5'd2, 64'd1), 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, trp(64'h8000_0008),
                         addi(64'h8000_000c, 32'h0030_0213, 5'd4, 64'd3), 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, addi(64'h8000_0010, 32'h0040_0293, 5'd5, 64'd4),
                         trp(64'h8000_0014), 1, 0));
`ifdef RVFI_GEN_COMPRESSED_EN
        tbl.push_back(vr(0, 0, 31'd0, st(64'd0, 32'h0000_e188, 0, 64'h8000_1000, 8'hff, 64'h1), zr, 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, st(64'h8000_0018, 32'h0000_e188, 1, 64'd0, 8'h00, 64'd0), zr, 0, 1));
`else
        tbl.push_back(vr(0, 0, 31'd0, st(64'h8000_0018, 32'h00a5_b023, 1, 64'h8000_1000, 8'hff, 64'h1), zr, 0, 1));
`endif
        tbl.push_back(vr(0, 0, 31'd0, zr, zr, 0, 1));
        run_table(1, "trap");

        // Zero-length sequence goes straight to the tohost store.
        tbl.delete();
        tbl.push_back(vr(1, 0, 31'd0, zr, zr, 1, 0));
`ifdef RVFI_GEN_COMPRESSED_EN
        tbl.push_back(vr(0, 0, 31'd0, st(64'd0, 32'h0000_e188, 0, 64'h8000_1000, 8'hff, 64'h1), zr, 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, st(64'h8000_0000, 32'h0000_e188, 1, 64'd0, 8'h00, 64'd0), zr, 0, 1));
`else
        tbl.push_back(vr(0, 0, 31'd0, st(64'h8000_0000, 32'h00a5_b023, 1, 64'h8000_1000, 8'hff, 64'h1), zr, 0, 1));
`endif
        tbl.push_back(vr(0, 0, 31'd0, zr, zr, 0, 1));
        run_table(2, "zero");

        // Asynchronous reset at idx=2, then restart from the boot address.
        do_reset();
        tbl.delete();
        tbl.push_back(vr(1, 0, 31'd0, zr, zr, 1, 0));
        tbl.push_back(vr(0, 0, 31'd0, addi(64'h8000_0000, 32'h0000_0093, 5'd1, 64'd0),
                         addi(64'h8000_0004, 32'h0010_0113, 5'd2, 64'd1), 1, 0));
        run_table(0, "prereset");
        #2 rst = 1'b1;
        #1;
        chk_port("async reset port0", o_m[0], zr);
        chk_port("async reset port1", o_m[1], zr);
        chk_bit("async reset busy", busy_m, 1'b0);
        chk_bit("async reset done", done_m, 1'b0);
        @(negedge clk); rst = 1'b0;
        run_table(0, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
